// File: rtl/stack_pkg.sv
// Shared defaults and the request decode for the LIFO stack.
package stack_pkg;

    localparam int STACK_WIDTH_DEFAULT = 4;
    localparam int STACK_DEPTH_DEFAULT = 8;

    // Encoding matches {push, pop} directly so decode is a plain cast.
    typedef enum logic [1:0] {
        NOP  = 2'b00,
        POP  = 2'b01,
        PUSH = 2'b10,
        SWAP = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic push_req, input logic pop_req);
        return op_e'({push_req, pop_req});
    endfunction

endpackage

// File: rtl/stack_behavioural.sv
// LIFO stack: inline storage array, saturating stack pointer, registered read word
// and full/empty flags decoded from the pointer alone.
module stack_behavioural
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH_DEFAULT,
    parameter int DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int SP_W   = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [WIDTH-1:0]  data_out_q;
    logic [WIDTH-1:0]  data_out_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    logic [SP_W-1:0]   sp_minus_one;
    logic [ADDR_W-1:0] free_addr;
    logic [ADDR_W-1:0] top_addr;
    op_e               op;

    assign full  = (sp_q == SP_FULL);
    assign empty = (sp_q == '0);

    // Both addresses are only used when the pointer is in range for them,
    // so dropping the pointer's top bit is safe.
    assign sp_minus_one = sp_q - SP_ONE;
    assign free_addr    = sp_q[ADDR_W-1:0];
    assign top_addr     = sp_minus_one[ADDR_W-1:0];

    assign op = decode_op(push, pop);

    always_comb begin
        sp_d       = sp_q;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        mem_waddr  = free_addr;
        mem_wdata  = data_in;

        unique case (op)
            PUSH: begin
                if (!full) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SP_ONE;
                end
            end
            POP: begin
                if (!empty) begin
                    data_out_d = mem_q[top_addr];
                    sp_d       = sp_minus_one;
                end
            end
            SWAP: begin
                // Empty stack has nothing to return, so this degrades to a push.
                if (empty) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SP_ONE;
                end else begin
                    data_out_d = mem_q[top_addr];
                    mem_we     = 1'b1;
                    mem_waddr  = top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sp_q       <= '0;
            data_out_q <= '0;
        end else begin
            sp_q       <= sp_d;
            data_out_q <= data_out_d;
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_stack_behavioural.sv
// Randomized and directed checks of stack_behavioural against a queue-based LIFO model.
module tb_stack_behavioural;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rstN;
    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int n_checks;
    int n_fails;
    int n_txn;

    // Reference: a queue whose back is the top of stack, plus the last popped word.
    int unsigned      stk[$];
    logic [WIDTH-1:0] m_dout;

    stack_behavioural #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .data_in (data_in),
        .push    (push),
        .pop     (pop),
        .data_out(data_out),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d required %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_empty();
        return stk.size() == 0;
    endfunction

    function automatic logic m_full();
        return stk.size() == DEPTH;
    endfunction

    task automatic model_step(input logic p, input logic q, input logic [WIDTH-1:0] d);
        if (p && q) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
            end else begin
                m_dout = WIDTH'(stk[stk.size()-1]);
                stk[stk.size()-1] = d;
            end
        end else if (p) begin
            if (stk.size() < DEPTH) stk.push_back(d);
        end else if (q) begin
            if (stk.size() > 0) m_dout = WIDTH'(stk.pop_back());
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout = '0;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic do_op(input logic p, input logic q, input logic [WIDTH-1:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        #2;
        check_eq("pre_edge_empty", empty, m_empty());
        check_eq("pre_edge_full", full, m_full());
        @(posedge clk);
        #1;
        model_step(p, q, d);
        check_eq("data_out", data_out, m_dout);
        check_eq("empty", empty, m_empty());
        check_eq("full", full, m_full());
        n_txn++;
        $display("txn %0d push=%0b pop=%0b din=%0d -> dout=%0d empty=%0b full=%0b depth=%0d",
                 n_txn, p, q, d, data_out, empty, full, stk.size());
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock edge.
    task automatic async_reset_midcycle();
        #3;
        rstN = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_empty", empty, 1);
        check_eq("async_rst_full", full, 0);
        check_eq("async_rst_dout", data_out, 0);
        #2;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_empty", empty, 1);
        $display("txn reset asserted between edges");
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        n_txn    = 0;
        rstN     = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        model_reset();

        // Reset held two cycles, then popping an empty stack.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dout", data_out, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        rstN = 1'b1;
        repeat (3) do_op(1'b0, 1'b1, 4'd0);
        check_eq("pop_empty_dout", data_out, 0);

        // Ordering.
        do_op(1'b1, 1'b0, 4'd13);
        check_eq("first_push_empty", empty, 0);
        do_op(1'b1, 1'b0, 4'd15);
        do_op(1'b1, 1'b0, 4'd2);
        do_op(1'b1, 1'b0, 4'd9);
        do_op(1'b0, 1'b1, 4'd0);
        check_eq("order_first_pop", data_out, 9);
        do_op(1'b1, 1'b0, 4'd3);
        do_op(1'b1, 1'b0, 4'd9);
        repeat (8) do_op(1'b0, 1'b1, 4'd0);
        check_eq("order_drain_hold", data_out, 13);
        check_eq("order_drain_empty", empty, 1);

        // Fill to full; ninth push dropped.
        for (int i = 1; i <= 9; i++) do_op(1'b1, 1'b0, WIDTH'(i));
        check_eq("fill_full", full, 1);
        for (int i = 8; i >= 1; i--) begin
            do_op(1'b0, 1'b1, 4'd0);
            check_eq("fill_pop_value", data_out, i);
        end
        check_eq("fill_drained_empty", empty, 1);

        // Simultaneous push and pop.
        do_op(1'b1, 1'b0, 4'd5);
        do_op(1'b1, 1'b0, 4'd6);
        do_op(1'b1, 1'b1, 4'd10);
        check_eq("swap_dout", data_out, 6);
        do_op(1'b0, 1'b1, 4'd0);
        check_eq("swap_replaced_top", data_out, 10);
        do_op(1'b0, 1'b1, 4'd0);
        check_eq("swap_bottom", data_out, 5);
        do_op(1'b1, 1'b1, 4'd4);
        check_eq("swap_empty_dout_held", data_out, 5);
        check_eq("swap_empty_pushed", empty, 0);
        do_op(1'b0, 1'b1, 4'd0);
        check_eq("swap_empty_value", data_out, 4);

        // Swap while full keeps full.
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, WIDTH'(i + 2));
        do_op(1'b1, 1'b1, 4'd14);
        check_eq("swap_full_dout", data_out, 9);
        check_eq("swap_full_still_full", full, 1);

        // Reset mid-operation, then a pop that must be ignored.
        do_op(1'b0, 1'b1, 4'd0);
        do_op(1'b1, 1'b0, 4'd7);
        async_reset_midcycle();
        do_op(1'b0, 1'b1, 4'd0);
        check_eq("post_rst_pop_ignored", data_out, 0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 59) == 0) begin
                async_reset_midcycle();
            end else if (r <= 3) begin
                do_op(1'b1, 1'b0, WIDTH'($urandom));
            end else if (r <= 6) begin
                do_op(1'b0, 1'b1, WIDTH'($urandom));
            end else if (r <= 8) begin
                do_op(1'b1, 1'b1, WIDTH'($urandom));
            end else begin
                do_op(1'b0, 1'b0, WIDTH'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/stack_behavioural.md
# stack_behavioural

LIFO stack with a registered read port and full/empty status flags. It buffers small data words and returns them in reverse order of arrival. The block is self-contained and sits between a producer and a consumer that share one clock domain. The push/pop controls are level-sensitive, with one operation per clock edge.

## Interface
Parameters:
- `WIDTH`, default 4: data word width in bits.
- `DEPTH`, default 8: number of entries; must be ≥ 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rstN`  input  1: reset, asynchronous and active-low.
- `data_in`  input  WIDTH: word to push.
- `push`  input  1: push request, sampled each rising edge.
- `pop`  input  1: pop request, sampled each rising edge.
- `data_out`  output  WIDTH: registered; last popped word.
- `full`  output  1: high when count == DEPTH.
- `empty`  output  1: high when count == 0.

## Operation
- State:
  - storage array `mem[DEPTH]` of WIDTH bits;
  - pointer/count `sp`, range 0..DEPTH, width $clog2(DEPTH+1);
  - `data_out` register.
- Top of stack is `mem[sp-1]`.
- Push only, not full: `mem[sp] <= data_in`, `sp <= sp+1`. `data_out` unchanged.
- Push only, full: ignored. No state change, no overwrite.
- Pop only, not empty: `data_out <= mem[sp-1]`, `sp <= sp-1`.
- Pop only, empty: ignored. `data_out` holds its previous value and `sp` stays 0.
- Push and pop together, not empty:
  - `data_out <= mem[sp-1]`;
  - `mem[sp-1] <= data_in`;
  - `sp` unchanged.
  - This applies even when full.
- Push and pop together, empty: behaves as push only.
- Neither asserted: all state holds.
- `full` and `empty` are combinational decodes of `sp` only. They never depend on `push`/`pop` in the same cycle.
- No pointer wrap-around. `sp` saturates at 0 and DEPTH through the ignore rules above.
- Popped entries are not cleared. Only `sp` moves.

## Timing
- Reset (`rstN` low, asynchronous, any time including mid-operation):
  - `sp = 0`, `data_out = 0`;
  - `empty = 1`, `full = 0`.
  - `mem` contents are don't-care and are not reset.
- Release of `rstN` is synchronous to `clk` by the integrator. The first operation is sampled on the first rising edge with `rstN` high.
- Push latency: the word is stored at edge N. `empty` falls and `full` rises immediately after edge N.
- Pop latency: `data_out` shows the popped word right after edge N and holds it until the next successful pop or reset.
- Continuous `pop` high drains one word per cycle. Once empty, `data_out` keeps the last popped value.
- No back-pressure handshake. The requester must observe `full`/`empty` itself; requests against them are dropped silently.

## Structure
- Single module `stack_behavioural`, behavioural RTL:
  - one `always_ff` for `mem`, `sp` and `data_out`;
  - continuous assigns for the flags.
- Optional package `stack_pkg`:
  - `STACK_WIDTH_DEFAULT = 4`;
  - `STACK_DEPTH_DEFAULT = 8`;
  - an `op_e` enum {NOP, PUSH, POP, SWAP} for decoding `{push, pop}`.
- No sub-module required. The storage array stays inline.

## Test plan
- **Reset, then pop on empty:** hold `rstN` low 2 cycles, then `pop = 1` for 3 cycles -> `data_out = 0`, `empty = 1`, `full = 0` throughout.
- **Push/pop ordering:**
  - push 13, 15, 2, 9 on consecutive edges -> `empty` falls after the first edge;
  - then pop 1 cycle -> `data_out = 9`;
  - then push 3, 9;
  - then hold `pop` 8 cycles -> `data_out` sequence 9, 3, 2, 15, 13, then holds 13 with `empty = 1`.
- **Fill to full:** push 1..9 (nine words) -> `full = 1` after the 8th push and the 9th is dropped. Eight pops then return 8, 7, …, 1, then `empty = 1`.
- **Simultaneous push and pop:**
  - with stack [5, 6] (top 6), assert both with `data_in = 10` -> `data_out = 6`, `sp` stays 2, next pop returns 10;
  - on empty, both asserted with `data_in = 4` -> acts as push, `data_out` unchanged.
- **Reset mid-operation:** after 3 pushes, drop `rstN` between clock edges -> `empty = 1`, `data_out = 0` immediately, without waiting for an edge. A subsequent pop is ignored.
- **Flag timing check:** the cycle a push or pop is requested, `full`/`empty` still reflect the old count. They change only after the edge.
